// File: rtl/flag_intr_unit.sv
// Flag and interrupt unit: C/Z/I flags with shadow save/restore for interrupt entry,
// plus a synchronized, debounced external interrupt that latches a pending request.
module flag_intr_unit #(
  parameter int unsigned DB_CYCLES = 4
) (
  input  logic CLK,
  input  logic RESET_N,
  input  logic INTR_IN,
  input  logic ALU_C,
  input  logic ALU_Z,
  input  logic FLG_C_SET,
  input  logic FLG_C_CLR,
  input  logic FLG_C_LD,
  input  logic FLG_Z_LD,
  input  logic FLG_SHAD_LD,
  input  logic FLG_LD_SEL,
  input  logic I_SET,
  input  logic I_CLR,
  output logic C_FLAG,
  output logic Z_FLAG,
  output logic I_FLAG,
  output logic INTR,
  output logic INTR_PEND
);

  localparam logic [7:0] DB_MAX = DB_CYCLES[7:0];

  logic       sync1_q, sync1_d;
  logic       sync2_q, sync2_d;
  logic [7:0] db_cnt_q, db_cnt_d;
  logic       db_prev_q, db_prev_d;
  logic       pend_q, pend_d;
  logic       c_q, c_d;
  logic       z_q, z_d;
  logic       i_q, i_d;
  logic       shad_c_q, shad_c_d;
  logic       shad_z_q, shad_z_d;
  logic       db_lvl_s;
  logic       db_edge_s;

  // State registers, all cleared asynchronously by RESET_N.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      db_cnt_q  <= 8'd0;
      db_prev_q <= 1'b0;
      pend_q    <= 1'b0;
      c_q       <= 1'b0;
      z_q       <= 1'b0;
      i_q       <= 1'b0;
      shad_c_q  <= 1'b0;
      shad_z_q  <= 1'b0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      db_cnt_q  <= db_cnt_d;
      db_prev_q <= db_prev_d;
      pend_q    <= pend_d;
      c_q       <= c_d;
      z_q       <= z_d;
      i_q       <= i_d;
      shad_c_q  <= shad_c_d;
      shad_z_q  <= shad_z_d;
    end
  end

  // Synchronizer, debounce counter and pending-interrupt latch.
  always_comb begin
    sync1_d = INTR_IN;
    sync2_d = sync1_q;

    if (sync2_q) begin
      if (db_cnt_q == DB_MAX) begin
        db_cnt_d = db_cnt_q;
      end else begin
        db_cnt_d = db_cnt_q + 8'd1;
      end
    end else begin
      db_cnt_d = 8'd0;
    end

    db_lvl_s  = (db_cnt_q == DB_MAX);
    db_edge_s = db_lvl_s & ~db_prev_q;
    db_prev_d = db_lvl_s;

    // A fresh edge beats the entry clear so a request arriving during entry survives.
    pend_d = db_edge_s | (pend_q & ~FLG_SHAD_LD);
  end

  // Flag next-state priority chains and shadow capture.
  always_comb begin
    if (FLG_SHAD_LD) begin
      c_d = 1'b0;
    end else if (FLG_C_CLR) begin
      c_d = 1'b0;
    end else if (FLG_C_SET) begin
      c_d = 1'b1;
    end else if (FLG_LD_SEL) begin
      c_d = shad_c_q;
    end else if (FLG_C_LD) begin
      c_d = ALU_C;
    end else begin
      c_d = c_q;
    end

    if (FLG_SHAD_LD) begin
      z_d = 1'b0;
    end else if (FLG_LD_SEL) begin
      z_d = shad_z_q;
    end else if (FLG_Z_LD) begin
      z_d = ALU_Z;
    end else begin
      z_d = z_q;
    end

    if (FLG_SHAD_LD) begin
      i_d = 1'b0;
    end else if (I_CLR) begin
      i_d = 1'b0;
    end else if (I_SET) begin
      i_d = 1'b1;
    end else begin
      i_d = i_q;
    end

    if (FLG_SHAD_LD) begin
      shad_c_d = c_q;
      shad_z_d = z_q;
    end else begin
      shad_c_d = shad_c_q;
      shad_z_d = shad_z_q;
    end
  end

  assign C_FLAG    = c_q;
  assign Z_FLAG    = z_q;
  assign I_FLAG    = i_q;
  assign INTR_PEND = pend_q;
  assign INTR      = pend_q & i_q;

endmodule
